// File: rtl/ucdp_latch_rf_pkg.sv
// Shared types for the latch-based register file.
// The staging op encoding is common to the top and any tooling that inspects it.
package ucdp_latch_rf_pkg;

   typedef enum logic [1:0] {
      OpNone  = 2'd0,
      OpWrite = 2'd1,
      OpClear = 2'd2
   } ucdp_latch_rf_op_e;

endpackage

// File: rtl/ucdp_latch_rf_entry.sv
// One register-file storage cell.
// It is a level-sensitive latch by default, or a rising-edge flop when FPGA is defined.
module ucdp_latch_rf_entry #(
   parameter int unsigned        width_p  = 8,
   parameter logic [width_p-1:0] rstval_p = {width_p{1'b0}}
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hit,
   input  logic               scan_mode,
   input  logic [width_p-1:0] nxt,
   output logic [width_p-1:0] q
);

`ifdef FPGA

   // The staged op lands one edge later; the top forwards it until then.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= rstval_p;
      end else if (hit || scan_mode) begin
         q <= nxt;
      end
   end

`else

   logic en;

   // Open only in the low phase, so the op staged at the rising edge is stable.
   assign en = rst | (hit & ~clk) | scan_mode;

   always_latch begin
      if (en) begin
         q <= rst ? rstval_p : nxt;
      end
   end

`endif

endmodule

// File: rtl/ucdp_latch_rf.sv
// Latch-based register file with flop staging, read forwarding and bulk clear.
// One write port, one combinational read port, with an FPGA flop fallback per entry.
module ucdp_latch_rf
   import ucdp_latch_rf_pkg::*;
#(
   parameter int unsigned        width_p  = 8,
   parameter int unsigned        depth_p  = 4,
   parameter logic [width_p-1:0] rstval_p = {width_p{1'b0}},
   localparam int unsigned       addrwidth_p = $clog2(depth_p)
) (
   input  logic                   main_clk_i,
   input  logic                   main_rst_i,
   input  logic                   wr_en_i,
   input  logic [addrwidth_p-1:0] wr_addr_i,
   input  logic [width_p-1:0]     wr_data_i,
   input  logic                   clr_i,
   input  logic [addrwidth_p-1:0] rd_addr_i,
   output logic [width_p-1:0]     rd_data_o,
   output logic                   busy_o,
   input  logic                   dft_mode_scan_mode_i
);

   ucdp_latch_rf_op_e      stg_op_d;
   ucdp_latch_rf_op_e      stg_op_q;
   logic [addrwidth_p-1:0] stg_addr_q;
   logic [width_p-1:0]     stg_data_q;

   logic                   wr_in_range;
   logic                   rd_in_range;
   logic [width_p-1:0]     entry_nxt;
   logic [depth_p-1:0]     entry_hit;
   logic [width_p-1:0]     entry_q [depth_p];
   logic [width_p-1:0]     rd_lat;

   assign wr_in_range = 32'(wr_addr_i) < depth_p;
   assign rd_in_range = 32'(rd_addr_i) < depth_p;

   // Clear wins over a simultaneous write, which is dropped.
   always_comb begin
      stg_op_d = OpNone;
      if (clr_i) begin
         stg_op_d = OpClear;
      end else if (wr_en_i && wr_in_range) begin
         stg_op_d = OpWrite;
      end
   end

   always_ff @(posedge main_clk_i or posedge main_rst_i) begin
      if (main_rst_i) begin
         stg_op_q   <= OpNone;
         stg_addr_q <= '0;
         stg_data_q <= rstval_p;
      end else begin
         stg_op_q   <= stg_op_d;
         stg_addr_q <= wr_addr_i;
         stg_data_q <= wr_data_i;
      end
   end

   assign entry_nxt = (stg_op_q == OpClear) ? rstval_p : stg_data_q;

   always_comb begin
      entry_hit = '0;
      for (int i = 0; i < int'(depth_p); i++) begin
         entry_hit[i] = (stg_op_q == OpClear) ||
                        ((stg_op_q == OpWrite) && (stg_addr_q == addrwidth_p'(i)));
      end
   end

   for (genvar g = 0; g < int'(depth_p); g++) begin : g_entry
      ucdp_latch_rf_entry #(
         .width_p  (width_p),
         .rstval_p (rstval_p)
      ) u_entry (
         .clk       (main_clk_i),
         .rst       (main_rst_i),
         .hit       (entry_hit[g]),
         .scan_mode (dft_mode_scan_mode_i),
         .nxt       (entry_nxt),
         .q         (entry_q[g])
      );
   end

   always_comb begin
      rd_lat = rstval_p;
      for (int i = 0; i < int'(depth_p); i++) begin
         if (rd_in_range && (rd_addr_i == addrwidth_p'(i))) begin
            rd_lat = entry_q[i];
         end
      end
   end

   // The staged op is not in the latches until the low phase, so forward it.
   always_comb begin
      if (stg_op_q == OpClear) begin
         rd_data_o = rstval_p;
      end else if ((stg_op_q == OpWrite) && (rd_addr_i == stg_addr_q)) begin
         rd_data_o = stg_data_q;
      end else begin
         rd_data_o = rd_lat;
      end
   end

   assign busy_o = (stg_op_q != OpNone);

endmodule

// File: tb/tb_ucdp_latch_rf.sv
// Directed, table-driven bench for ucdp_latch_rf (depth 4) plus a depth-3 instance
// for out-of-range addressing and scan mode.
module tb_ucdp_latch_rf;

   localparam logic [7:0] Rst = 8'hA5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [1:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       clr = 1'b0;
   logic [1:0] rd_addr = '0;
   logic       scan = 1'b0;
   logic [7:0] rd4, rd3;
   logic       busy4, busy3;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ucdp_latch_rf #(.width_p(8), .depth_p(4), .rstval_p(Rst)) dut (
      .main_clk_i           (clk),
      .main_rst_i           (rst),
      .wr_en_i              (wr_en),
      .wr_addr_i            (wr_addr),
      .wr_data_i            (wr_data),
      .clr_i                (clr),
      .rd_addr_i            (rd_addr),
      .rd_data_o            (rd4),
      .busy_o               (busy4),
      .dft_mode_scan_mode_i (scan)
   );

   ucdp_latch_rf #(.width_p(8), .depth_p(3), .rstval_p(Rst)) dut3 (
      .main_clk_i           (clk),
      .main_rst_i           (rst),
      .wr_en_i              (wr_en),
      .wr_addr_i            (wr_addr),
      .wr_data_i            (wr_data),
      .clr_i                (clr),
      .rd_addr_i            (rd_addr),
      .rd_data_o            (rd3),
      .busy_o               (busy3),
      .dft_mode_scan_mode_i (scan)
   );

   typedef struct {
      logic       wr_en;
      logic [1:0] wr_addr;
      logic [7:0] wr_data;
      logic       clr;
      logic [1:0] rd_addr;
      logic [7:0] exp_rd;
      logic       exp_busy;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the capturing edge.
   task automatic cycle(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                        input logic cl, input logic [1:0] ra);
      wr_en   = we;
      wr_addr = wa;
      wr_data = wd;
      clr     = cl;
      rd_addr = ra;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          we    wa     wd     clr   ra     exp    busy
      vecs[0]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'hA5, 1'b0};
      vecs[1]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 8'hA5, 1'b0};
      vecs[2]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 8'hA5, 1'b0};
      vecs[3]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 8'hA5, 1'b0};
      vecs[4]  = '{1'b1, 2'd2, 8'h3C, 1'b0, 2'd2, 8'h3C, 1'b1};
      vecs[5]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 8'h3C, 1'b0};
      vecs[6]  = '{1'b1, 2'd0, 8'h01, 1'b0, 2'd0, 8'h01, 1'b1};
      vecs[7]  = '{1'b1, 2'd0, 8'h02, 1'b0, 2'd0, 8'h02, 1'b1};
      vecs[8]  = '{1'b1, 2'd0, 8'h03, 1'b0, 2'd0, 8'h03, 1'b1};
      vecs[9]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h03, 1'b0};
      vecs[10] = '{1'b1, 2'd1, 8'h11, 1'b0, 2'd0, 8'h03, 1'b1};
      vecs[11] = '{1'b1, 2'd0, 8'h04, 1'b0, 2'd1, 8'h11, 1'b1};
      vecs[12] = '{1'b1, 2'd1, 8'h12, 1'b0, 2'd0, 8'h04, 1'b1};
      vecs[13] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 8'h12, 1'b0};
      vecs[14] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h04, 1'b0};
      vecs[15] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 8'h3C, 1'b0};
      vecs[16] = '{1'b1, 2'd1, 8'hFF, 1'b1, 2'd1, 8'hA5, 1'b1};
      vecs[17] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'hA5, 1'b0};
      vecs[18] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 8'hA5, 1'b0};
      vecs[19] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 8'hA5, 1'b0};
      vecs[20] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 8'hA5, 1'b0};
      vecs[21] = '{1'b1, 2'd3, 8'h55, 1'b0, 2'd2, 8'hA5, 1'b1};
      vecs[22] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 8'h55, 1'b0};

      // Reset state, sampled while reset is held.
      @(posedge clk);
      @(posedge clk);
      #1;
      for (int a = 0; a < 4; a++) begin
         rd_addr = 2'(a);
         #1;
         check($sformatf("reset_rd%0d", a), rd4, Rst);
      end
      check("reset_busy", {7'd0, busy4}, 8'h00);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         cycle(vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data, vecs[i].clr, vecs[i].rd_addr);
         check($sformatf("vec%0d_rd", i), rd4, vecs[i].exp_rd);
         check($sformatf("vec%0d_busy", i), {7'd0, busy4}, {7'd0, vecs[i].exp_busy});
      end

      // Reset during the high phase, before the staged write reaches its latch.
      cycle(1'b1, 2'd3, 8'h77, 1'b0, 2'd3);
      check("midrst_fwd", rd4, 8'h77);
      wr_en = 1'b0;
      rst   = 1'b1;
      #1;
      check("midrst_busy", {7'd0, busy4}, 8'h00);
      check("midrst_rd", rd4, Rst);
      @(negedge clk);
      #1;
      check("midrst_low_rd", rd4, Rst);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd3);
      check("postrst_rd3", rd4, Rst);
      check("postrst_busy", {7'd0, busy4}, 8'h00);

      // Depth-3 instance: out-of-range write and read.
      cycle(1'b1, 2'd3, 8'h99, 1'b0, 2'd3);
      check("d3_oor_busy", {7'd0, busy3}, 8'h00);
      check("d3_oor_rd", rd3, Rst);
      cycle(1'b1, 2'd2, 8'h5A, 1'b0, 2'd2);
      check("d3_wr2_fwd", rd3, 8'h5A);
      check("d3_wr2_busy", {7'd0, busy3}, 8'h01);
      cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd2);
      check("d3_rd2", rd3, 8'h5A);
      cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd3);
      check("d3_rd3", rd3, Rst);

      // Scan mode: every entry follows the staged next value.
      scan = 1'b1;
      cycle(1'b1, 2'd1, 8'hC3, 1'b0, 2'd0);
      check("d3_scan_rd0", rd3, 8'hC3);
      check("d3_scan_busy", {7'd0, busy3}, 8'h01);
      rd_addr = 2'd2;
      #1;
      check("d3_scan_rd2", rd3, 8'hC3);
      scan = 1'b0;
      wr_data = 8'h00;
      cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd1);
      check("d3_post_scan_rd1", rd3, 8'hC3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
